// File: rtl/ray_bounce_sched_if.sv
// Signal bundle around ray_bounce_sched: camera input, reflector results, tracer output, pixels.
// The slave modport is the scheduler's view; master is the surrounding pipeline's view.
interface ray_bounce_sched_if #(
   parameter int TAG_BITS     = 19,
   parameter int FP_VEC3_BITS = 72
);
   logic                    cam_valid;
   logic                    cam_ready;
   logic [FP_VEC3_BITS-1:0] cam_origin;
   logic [FP_VEC3_BITS-1:0] cam_dir;
   logic [TAG_BITS-1:0]     cam_tag;

   logic                    refl_done;
   logic [FP_VEC3_BITS-1:0] refl_origin;
   logic [FP_VEC3_BITS-1:0] refl_dir;
   logic [FP_VEC3_BITS-1:0] refl_color;
   logic [FP_VEC3_BITS-1:0] refl_light;
   logic [TAG_BITS-1:0]     refl_tag;
   logic [3:0]              refl_bounce;
   logic                    refl_term;

   logic                    trace_valid;
   logic                    trace_ready;
   logic [FP_VEC3_BITS-1:0] trace_origin;
   logic [FP_VEC3_BITS-1:0] trace_dir;
   logic [FP_VEC3_BITS-1:0] trace_color;
   logic [FP_VEC3_BITS-1:0] trace_light;
   logic [TAG_BITS-1:0]     trace_tag;
   logic [3:0]              trace_bounce;

   logic                    pix_valid;
   logic [FP_VEC3_BITS-1:0] pix_light;
   logic [TAG_BITS-1:0]     pix_tag;

   logic                    overflow;

   modport slave (
      input  cam_valid, cam_origin, cam_dir, cam_tag,
      output cam_ready,
      input  refl_done, refl_origin, refl_dir, refl_color, refl_light,
      input  refl_tag, refl_bounce, refl_term,
      output trace_valid, trace_origin, trace_dir, trace_color, trace_light,
      output trace_tag, trace_bounce,
      input  trace_ready,
      output pix_valid, pix_light, pix_tag,
      output overflow
   );

   modport master (
      output cam_valid, cam_origin, cam_dir, cam_tag,
      input  cam_ready,
      output refl_done, refl_origin, refl_dir, refl_color, refl_light,
      output refl_tag, refl_bounce, refl_term,
      input  trace_valid, trace_origin, trace_dir, trace_color, trace_light,
      input  trace_tag, trace_bounce,
      output trace_ready,
      input  pix_valid, pix_light, pix_tag,
      input  overflow
   );
endinterface

// File: rtl/ray_bounce_sched.sv
// Retires or recirculates reflected rays and arbitrates recirculated vs camera rays into the tracer.
// Optional macro RAY_BOUNCE_SCHED_DARK_KILL_EN also retires rays whose colour is entirely zero.
module ray_bounce_sched #(
   parameter int MAX_BOUNCES = 4,
   parameter int FIFO_DEPTH  = 64,
   parameter int TAG_BITS    = 19
) (
   input logic              clk,
   input logic              rst,
   ray_bounce_sched_if.slave bus
);
   localparam int               FP_BITS      = 24;
   localparam int               FP_VEC3_BITS = 3 * FP_BITS;
   localparam logic [FP_BITS-1:0] FP_ONE     = 24'h3f8000;
   localparam int               AW           = $clog2(FIFO_DEPTH);
   localparam int               CW           = AW + 1;

   typedef struct packed {
      logic [FP_VEC3_BITS-1:0] origin;
      logic [FP_VEC3_BITS-1:0] dir;
      logic [FP_VEC3_BITS-1:0] color;
      logic [FP_VEC3_BITS-1:0] light;
      logic [TAG_BITS-1:0]     tag;
      logic [3:0]              bounce;
   } ray_t;

   ray_t                    mem_q [FIFO_DEPTH];
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [CW-1:0]           inflight_q, inflight_d;
   ray_t                    trace_q, trace_d;
   logic                    trace_valid_q, trace_valid_d;
   logic                    pix_valid_q, pix_valid_d;
   logic [FP_VEC3_BITS-1:0] pix_light_q, pix_light_d;
   logic [TAG_BITS-1:0]     pix_tag_q, pix_tag_d;
   logic                    overflow_q, overflow_d;

   logic [4:0] next_bounce;
   logic       dark;
   logic       retire;
   logic       push;
   logic       write_en;
   logic       pop;
   logic       fifo_empty;
   logic       fifo_full;
   logic       load_ok;
   logic       cam_ready;
   logic       cam_accept;
   ray_t       push_ray;
   ray_t       cam_ray;

   // Sign bits are ignored so that -0.0 also counts as a dark component.
`ifdef RAY_BOUNCE_SCHED_DARK_KILL_EN
   assign dark = (bus.refl_color[FP_BITS-2:0] == '0) &&
                 (bus.refl_color[2*FP_BITS-2:FP_BITS] == '0) &&
                 (bus.refl_color[3*FP_BITS-2:2*FP_BITS] == '0);
`else
   assign dark = 1'b0;
`endif

   always_comb begin
      next_bounce = {1'b0, bus.refl_bounce} + 5'd1;
      retire      = bus.refl_term || (next_bounce >= 5'(MAX_BOUNCES)) || dark;
      push        = bus.refl_done && !retire;

      push_ray.origin = bus.refl_origin;
      push_ray.dir    = bus.refl_dir;
      push_ray.color  = bus.refl_color;
      push_ray.light  = bus.refl_light;
      push_ray.tag    = bus.refl_tag;
      push_ray.bounce = next_bounce[3:0];

      cam_ray.origin = bus.cam_origin;
      cam_ray.dir    = bus.cam_dir;
      cam_ray.color  = {FP_ONE, FP_ONE, FP_ONE};
      cam_ray.light  = '0;
      cam_ray.tag    = bus.cam_tag;
      cam_ray.bounce = 4'd0;

      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == CW'(FIFO_DEPTH));
      load_ok    = !trace_valid_q || bus.trace_ready;
      pop        = load_ok && !fifo_empty;
      // A full FIFO may still take a push when the head leaves in the same cycle.
      write_en   = push && (!fifo_full || pop);
      cam_ready  = !rst && fifo_empty && (inflight_q < CW'(FIFO_DEPTH)) && load_ok;
      cam_accept = bus.cam_valid && cam_ready;
   end

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      count_d       = count_q;
      inflight_d    = inflight_q;
      trace_d       = trace_q;
      trace_valid_d = trace_valid_q;
      pix_valid_d   = bus.refl_done && retire;
      pix_light_d   = pix_light_q;
      pix_tag_d     = pix_tag_q;
      overflow_d    = overflow_q || (push && fifo_full && !pop);

      if (write_en) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({write_en, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // Recirculated rays always win over fresh camera rays for the tracer slot.
      if (pop) begin
         trace_d       = mem_q[rd_ptr_q];
         trace_valid_d = 1'b1;
      end else if (cam_accept) begin
         trace_d       = cam_ray;
         trace_valid_d = 1'b1;
      end else if (load_ok) begin
         trace_valid_d = 1'b0;
      end

      case ({cam_accept, pix_valid_q})
         2'b10:   inflight_d = inflight_q + 1'b1;
         2'b01:   inflight_d = inflight_q - 1'b1;
         default: inflight_d = inflight_q;
      endcase

      if (bus.refl_done && retire) begin
         pix_light_d = bus.refl_light;
         pix_tag_d   = bus.refl_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         inflight_q    <= '0;
         trace_q       <= '0;
         trace_valid_q <= 1'b0;
         pix_valid_q   <= 1'b0;
         pix_light_q   <= '0;
         pix_tag_q     <= '0;
         overflow_q    <= 1'b0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
         inflight_q    <= inflight_d;
         trace_q       <= trace_d;
         trace_valid_q <= trace_valid_d;
         pix_valid_q   <= pix_valid_d;
         pix_light_q   <= pix_light_d;
         pix_tag_q     <= pix_tag_d;
         overflow_q    <= overflow_d;
      end
   end

   // Storage needs no reset; the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (write_en) begin
         mem_q[wr_ptr_q] <= push_ray;
      end
   end

   assign bus.cam_ready    = cam_ready;
   assign bus.trace_valid  = trace_valid_q;
   assign bus.trace_origin = trace_q.origin;
   assign bus.trace_dir    = trace_q.dir;
   assign bus.trace_color  = trace_q.color;
   assign bus.trace_light  = trace_q.light;
   assign bus.trace_tag    = trace_q.tag;
   assign bus.trace_bounce = trace_q.bounce;
   assign bus.pix_valid    = pix_valid_q;
   assign bus.pix_light    = pix_light_q;
   assign bus.pix_tag      = pix_tag_q;
   assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_ray_bounce_sched.sv
// Directed bench for ray_bounce_sched: retire-rule vector table plus hand-written
// sequences for camera launch, recirculation, credits, FIFO full/overflow and async reset.
module tb_ray_bounce_sched;
   localparam int          TAG_BITS = 19;
   localparam int          VB       = 72;
   localparam logic [23:0] FP_ONE   = 24'h3f8000;
   localparam logic [71:0] COL      = 72'h3f0000_3f0000_3f0000;
   localparam logic [71:0] ORG      = 72'h111111_222222_333333;
   localparam logic [71:0] DIR      = 72'h444444_555555_666666;
`ifdef RAY_BOUNCE_SCHED_DARK_KILL_EN
   localparam logic DARK_KILL = 1'b1;
`else
   localparam logic DARK_KILL = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   ray_bounce_sched_if #(.TAG_BITS(TAG_BITS), .FP_VEC3_BITS(VB)) bus ();

   ray_bounce_sched #(.MAX_BOUNCES(4), .FIFO_DEPTH(64), .TAG_BITS(TAG_BITS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic [3:0]    bounce;
      logic          term;
      logic [71:0]   color;
      logic [18:0]   tag;
      logic [71:0]   light;
      logic          exp_pix;
      logic          exp_push;
      logic [3:0]    exp_bounce;
   } vec_t;

   vec_t vecs [10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [3:0] bounce, input logic term, input logic [71:0] color,
                                 input logic [18:0] tag, input logic [71:0] light);
      bus.refl_done   = 1'b1;
      bus.refl_bounce = bounce;
      bus.refl_term   = term;
      bus.refl_color  = color;
      bus.refl_tag    = tag;
      bus.refl_light  = light;
      bus.refl_origin = ORG ^ {53'h0, tag};
      bus.refl_dir    = DIR;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic drain(input int base, input int n);
      int bad = 0;
      bus.trace_ready = 1'b1;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (bus.trace_valid !== 1'b1 || bus.trace_tag !== 19'(base + k)) bad++;
      end
      check_output("drain_order", 128'(bad), 128'(0));
      tick();
      check_output("drain_empty", 128'(bus.trace_valid), 128'(0));
   endtask

   function automatic vec_t mk(input string name, input logic [3:0] b, input logic t,
                               input logic [71:0] c, input int tag,
                               input logic ep, input logic eu, input logic [3:0] eb);
      vec_t v;
      v.name = name; v.bounce = b; v.term = t; v.color = c; v.tag = 19'(tag);
      v.light = {24'h3f0000, 24'(tag), 24'h000001};
      v.exp_pix = ep; v.exp_push = eu; v.exp_bounce = eb;
      return v;
   endfunction

   initial begin
      int bad;
      vecs[0] = mk("b0_push",     4'd0,  1'b0, COL, 101, 1'b0, 1'b1, 4'd1);
      vecs[1] = mk("b1_push",     4'd1,  1'b0, COL, 102, 1'b0, 1'b1, 4'd2);
      vecs[2] = mk("b2_push",     4'd2,  1'b0, COL, 103, 1'b0, 1'b1, 4'd3);
      vecs[3] = mk("b3_retire",   4'd3,  1'b0, COL, 104, 1'b1, 1'b0, 4'd0);
      vecs[4] = mk("term_retire", 4'd0,  1'b1, COL, 105, 1'b1, 1'b0, 4'd0);
      vecs[5] = mk("b15_retire",  4'd15, 1'b0, COL, 106, 1'b1, 1'b0, 4'd0);
      vecs[6] = mk("dark_zero",   4'd0,  1'b0, 72'h0, 107, DARK_KILL, !DARK_KILL, 4'd1);
      vecs[7] = mk("dark_signs",  4'd0,  1'b0, 72'h800000_800000_800000, 108, DARK_KILL, !DARK_KILL, 4'd1);
      vecs[8] = mk("color_lsb",   4'd2,  1'b0, 72'h000000_000001_000000, 109, 1'b0, 1'b1, 4'd3);
      vecs[9] = mk("term_b2",     4'd2,  1'b1, COL, 110, 1'b1, 1'b0, 4'd0);

      bus.cam_valid = 1'b1; bus.cam_origin = ORG; bus.cam_dir = DIR; bus.cam_tag = '0;
      bus.refl_done = 1'b0; bus.refl_origin = '0; bus.refl_dir = '0; bus.refl_color = '0;
      bus.refl_light = '0; bus.refl_tag = '0; bus.refl_bounce = '0; bus.refl_term = 1'b0;
      bus.trace_ready = 1'b1;

      // Reset state while rst is held with an eager camera
      tick();
      check_output("rst_trace_valid", 128'(bus.trace_valid), 128'(0));
      check_output("rst_pix_valid",   128'(bus.pix_valid),   128'(0));
      check_output("rst_overflow",    128'(bus.overflow),    128'(0));
      check_output("rst_cam_ready",   128'(bus.cam_ready),   128'(0));
      check_output("rst_inflight",    128'(dut.inflight_q),  128'(0));
      check_output("rst_trace_tag",   128'(bus.trace_tag),   128'(0));
      check_output("rst_pix_light",   128'(bus.pix_light),   128'(0));
      bus.cam_valid = 1'b0;
      rst = 1'b0;
      tick();

      // Retire-rule table
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].bounce, vecs[i].term, vecs[i].color, vecs[i].tag, vecs[i].light);
         tick();
         bus.refl_done = 1'b0;
         check_output({vecs[i].name, "_pix_valid"}, 128'(bus.pix_valid), 128'(vecs[i].exp_pix));
         if (vecs[i].exp_pix) begin
            check_output({vecs[i].name, "_pix_tag"},   128'(bus.pix_tag),   128'(vecs[i].tag));
            check_output({vecs[i].name, "_pix_light"}, 128'(bus.pix_light), 128'(vecs[i].light));
         end
         check_output({vecs[i].name, "_trace_early"}, 128'(bus.trace_valid), 128'(0));
         tick();
         check_output({vecs[i].name, "_trace_valid"}, 128'(bus.trace_valid), 128'(vecs[i].exp_push));
         check_output({vecs[i].name, "_pix_pulse"},   128'(bus.pix_valid),   128'(0));
         if (vecs[i].exp_push) begin
            check_output({vecs[i].name, "_bounce"}, 128'(bus.trace_bounce), 128'(vecs[i].exp_bounce));
            check_output({vecs[i].name, "_tag"},    128'(bus.trace_tag),    128'(vecs[i].tag));
            check_output({vecs[i].name, "_color"},  128'(bus.trace_color),  128'(vecs[i].color));
            check_output({vecs[i].name, "_light"},  128'(bus.trace_light),  128'(vecs[i].light));
            check_output({vecs[i].name, "_origin"}, 128'(bus.trace_origin), 128'(ORG ^ {53'h0, vecs[i].tag}));
            check_output({vecs[i].name, "_dir"},    128'(bus.trace_dir),    128'(DIR));
         end
         tick();
      end
      check_output("table_overflow", 128'(bus.overflow), 128'(0));

      // Camera launch
      do_reset();
      bus.trace_ready = 1'b1; bus.cam_valid = 1'b1; bus.cam_tag = 19'd5;
      #1;
      check_output("cam_ready_first", 128'(bus.cam_ready), 128'(1));
      tick();
      bus.cam_valid = 1'b0;
      check_output("cam_trace_valid",  128'(bus.trace_valid),  128'(1));
      check_output("cam_trace_tag",    128'(bus.trace_tag),    128'(5));
      check_output("cam_trace_bounce", 128'(bus.trace_bounce), 128'(0));
      check_output("cam_trace_color",  128'(bus.trace_color),  128'({FP_ONE, FP_ONE, FP_ONE}));
      check_output("cam_trace_light",  128'(bus.trace_light),  128'(0));
      check_output("cam_trace_origin", 128'(bus.trace_origin), 128'(ORG));
      check_output("cam_inflight",     128'(dut.inflight_q),   128'(1));

      // Recirculation with bounce 1, and camera blocked while the FIFO holds it
      apply_stimulus(4'd1, 1'b0, COL, 19'd5, 72'h1234);
      tick();
      bus.refl_done = 1'b0; bus.cam_valid = 1'b1; bus.cam_tag = 19'd6;
      #1;
      check_output("recirc_trace_gap",   128'(bus.trace_valid), 128'(0));
      check_output("recirc_cam_blocked", 128'(bus.cam_ready),   128'(0));
      tick();
      check_output("recirc_trace_valid",  128'(bus.trace_valid),  128'(1));
      check_output("recirc_trace_bounce", 128'(bus.trace_bounce), 128'(2));
      check_output("recirc_trace_tag",    128'(bus.trace_tag),    128'(5));
      check_output("recirc_trace_light",  128'(bus.trace_light),  128'(72'h1234));
      check_output("recirc_cam_ready",    128'(bus.cam_ready),    128'(1));
      tick();
      bus.cam_valid = 1'b0;
      check_output("cam2_trace_tag", 128'(bus.trace_tag),   128'(6));
      check_output("cam2_inflight",  128'(dut.inflight_q),  128'(2));

      // Bounce-limit retire
      apply_stimulus(4'd3, 1'b0, COL, 19'd77, {24'h3f0000, 48'h0});
      tick();
      bus.refl_done = 1'b0;
      check_output("retire_pix_valid", 128'(bus.pix_valid),   128'(1));
      check_output("retire_pix_tag",   128'(bus.pix_tag),     128'(77));
      check_output("retire_pix_light", 128'(bus.pix_light),   128'({24'h3f0000, 48'h0}));
      check_output("retire_no_push",   128'(bus.trace_valid), 128'(0));
      tick();
      check_output("retire_inflight",  128'(dut.inflight_q),  128'(1));
      check_output("retire_pix_pulse", 128'(bus.pix_valid),   128'(0));
      check_output("retire_no_trace",  128'(bus.trace_valid), 128'(0));

      // Pixel and camera accept in the same cycle
      apply_stimulus(4'd0, 1'b1, COL, 19'd9, 72'h99);
      tick();
      bus.refl_done = 1'b0; bus.cam_valid = 1'b1; bus.cam_tag = 19'd10;
      #1;
      check_output("simul_pix_valid", 128'(bus.pix_valid), 128'(1));
      check_output("simul_cam_ready", 128'(bus.cam_ready), 128'(1));
      tick();
      bus.cam_valid = 1'b0;
      check_output("simul_inflight",  128'(dut.inflight_q),  128'(1));
      check_output("simul_trace_tag", 128'(bus.trace_tag),   128'(10));

      // Accept 64 camera rays, then stall the tracer
      do_reset();
      bus.trace_ready = 1'b1; bus.cam_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 64; i++) begin
         bus.cam_tag = 19'(i);
         #1;
         if (bus.cam_ready !== 1'b1) bad++;
         tick();
      end
      check_output("fill_accepts",  128'(bad),            128'(0));
      check_output("fill_inflight", 128'(dut.inflight_q), 128'(64));
      check_output("fill_cam_ready",128'(bus.cam_ready),  128'(0));
      check_output("fill_last_tag", 128'(bus.trace_tag),  128'(63));
      bus.trace_ready = 1'b0; bus.cam_tag = 19'd99; bus.cam_origin = ~ORG;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.trace_valid !== 1'b1 || bus.trace_tag !== 19'd63 ||
             bus.trace_origin !== ORG || bus.cam_ready !== 1'b0) bad++;
      end
      check_output("stall_hold", 128'(bad), 128'(0));
      bus.cam_valid = 1'b0; bus.cam_origin = ORG;

      // 64 consecutive recirculations fill the FIFO exactly
      for (int i = 0; i < 64; i++) begin
         apply_stimulus(4'd0, 1'b0, COL, 19'(100 + i), 72'h0);
         tick();
      end
      bus.refl_done = 1'b0;
      check_output("full_overflow", 128'(bus.overflow), 128'(0));
      apply_stimulus(4'd0, 1'b0, COL, 19'd164, 72'h0);
      bus.trace_ready = 1'b1;
      tick();
      bus.refl_done = 1'b0;
      check_output("full_pushpop_overflow", 128'(bus.overflow),     128'(0));
      check_output("full_pushpop_head",     128'(bus.trace_tag),    128'(100));
      check_output("full_pushpop_bounce",   128'(bus.trace_bounce), 128'(1));
      drain(100, 64);

      // Forced overflow: the 66th push meets a full FIFO with no pop
      bus.trace_ready = 1'b0;
      for (int i = 0; i < 65; i++) begin
         apply_stimulus(4'd0, 1'b0, COL, 19'(200 + i), 72'h0);
         tick();
      end
      check_output("ovf_before", 128'(bus.overflow), 128'(0));
      apply_stimulus(4'd0, 1'b0, COL, 19'd265, 72'h0);
      tick();
      bus.refl_done = 1'b0;
      check_output("ovf_set", 128'(bus.overflow), 128'(1));
      tick();
      tick();
      check_output("ovf_sticky", 128'(bus.overflow), 128'(1));
      drain(200, 64);

      // Asynchronous reset mid-operation
      bus.trace_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(4'd0, 1'b0, COL, 19'(300 + i), 72'h0);
         tick();
      end
      bus.refl_done = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      check_output("arst_trace_valid", 128'(bus.trace_valid), 128'(0));
      check_output("arst_overflow",    128'(bus.overflow),    128'(0));
      check_output("arst_inflight",    128'(dut.inflight_q),  128'(0));
      check_output("arst_cam_ready",   128'(bus.cam_ready),   128'(0));
      tick();
      rst = 1'b0;
      bus.trace_ready = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.trace_valid !== 1'b0 || bus.pix_valid !== 1'b0) bad++;
      end
      check_output("arst_fifo_discarded", 128'(bad),           128'(0));
      check_output("arst_cam_ready_back", 128'(bus.cam_ready), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
